hazard_ctrl: RTL and testbench

Pipeline sequencing and hazard controller for the 5-stage RV32 core. It owns the run state of the pipeline: frozen after reset, released by `start`, and drained to a clean halt on an EBREAK in decode. While running it generates load-use stalls, branch/jump flushes and EX-stage operand forwarding selects. Optional performance counters are included. It sits beside the five stage blocks in the top level and drives their stall, flush and forward controls.

---
 rtl/pipeline_pkg.sv | 35 +++
 rtl/forwarding_unit.sv | 20 ++
 rtl/hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared encodings for the pipeline hazard/sequencing logic.
// Latency: n/a (types, constants, pure helper function).
// Backpressure: n/a.
package pipeline_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] DRAIN_LOAD = 2'd1;

    // M-stage result is younger than W, so it wins when both match.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       wr_m,
        input logic [4:0] rd_w,
        input logic       wr_w
    );
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
            return FWD_MEM;
        else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/forwarding_unit.sv
// EX-stage operand forwarding select for both ALU sources.
// Latency: purely combinational, zero cycles.
// Backpressure: none; always valid from current RS/RD/RegWrite inputs.
module forwarding_unit
    import pipeline_pkg::*;
(
    input  logic [4:0] RS1_E,
    input  logic [4:0] RS2_E,
    input  logic [4:0] RD_M,
    input  logic [4:0] RDW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE
);

    assign ForwardAE = fwd_sel(RS1_E, RD_M, RegWriteM, RDW, RegWriteW);
    assign ForwardBE = fwd_sel(RS2_E, RD_M, RegWriteM, RDW, RegWriteW);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline run-state FSM, load-use stall, branch flush and forwarding; counters under HAZARD_PERF_CNT_EN.
// Latency: stall/flush/forward combinational; running/halted/counters registered (1 cycle).
// Backpressure: stalls F/D on load-use or halt accept; freezes whole front end outside RUN.
module hazard_ctrl
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        halt_req,
    input  logic [4:0]  RS1_D,
    input  logic [4:0]  RS2_D,
    input  logic [4:0]  RS1_E,
    input  logic [4:0]  RS2_E,
    input  logic [4:0]  RD_E,
    input  logic [4:0]  RD_M,
    input  logic [4:0]  RDW,
    input  logic        ResultSrcE,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        PCSrcE,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushD,
    output logic        FlushE,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        running,
    output logic        halted,
    output logic [31:0] cycle_cnt,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    state_t     state, next_state;
    logic [1:0] drain_cnt, drain_nxt;
    logic       lw_stall;
    logic       halt_acc;

    assign lw_stall = ResultSrcE && (RD_E != 5'd0) &&
                      ((RD_E == RS1_D) || (RD_E == RS2_D));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            drain_cnt <= 2'd0;
            running   <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state     <= next_state;
            drain_cnt <= drain_nxt;
            running   <= (next_state == ST_RUN);
            halted    <= (next_state == ST_HALTED);
        end
    end

    always_comb begin
        next_state = state;
        drain_nxt  = drain_cnt;
        halt_acc   = 1'b0;
        StallF     = 1'b1;
        StallD     = 1'b1;
        FlushD     = 1'b1;
        FlushE     = 1'b1;
        case (state)
            ST_IDLE: begin
                if (start)
                    next_state = ST_RUN;
            end
            ST_RUN: begin
                // A taken branch flushes the EBREAK, so it can never be accepted alongside PCSrcE.
                halt_acc = halt_req && !PCSrcE && !lw_stall;
                StallD   = lw_stall && !PCSrcE;
                StallF   = (lw_stall && !PCSrcE) || halt_acc;
                FlushD   = PCSrcE || halt_acc;
                FlushE   = lw_stall || PCSrcE || halt_acc;
                if (halt_acc) begin
                    next_state = ST_DRAIN;
                    drain_nxt  = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == 2'd0)
                    next_state = ST_HALTED;
                else
                    drain_nxt = drain_cnt - 2'd1;
            end
            ST_HALTED: begin
                next_state = ST_HALTED;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
        if (rst) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushD = 1'b1;
            FlushE = 1'b1;
        end
    end

    forwarding_unit u_fwd (
        .RS1_E     (RS1_E),
        .RS2_E     (RS2_E),
        .RD_M      (RD_M),
        .RDW       (RDW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE)
    );

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] cycle_q, stall_q, flush_q;
    logic        stall_evt, flush_evt;

    assign stall_evt = (state == ST_RUN) && lw_stall && !PCSrcE;
    assign flush_evt = (state == ST_RUN) && PCSrcE;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q <= 32'd0;
            stall_q <= 32'd0;
            flush_q <= 32'd0;
        end else begin
            if ((state == ST_RUN) || (state == ST_DRAIN))
                cycle_q <= cycle_q + 32'd1;
            if (stall_evt)
                stall_q <= stall_q + 32'd1;
            if (flush_evt)
                flush_q <= flush_q + 32'd1;
        end
    end

    assign cycle_cnt = cycle_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign cycle_cnt = 32'd0;
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl against a behavioural model.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, halt_req;
    logic [4:0]  RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RDW;
    logic        ResultSrcE, RegWriteM, RegWriteW, PCSrcE;
    logic        StallF, StallD, FlushD, FlushE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        running, halted;
    logic [31:0] cycle_cnt, stall_cnt, flush_cnt;

    hazard_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
        .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E),
        .RD_E(RD_E), .RD_M(RD_M), .RDW(RDW),
        .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .running(running), .halted(halted),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 run, 2 drain, 3 halted; halt timing tracked as cycles since accept.
    int          m_mode;
    int          m_since_acc;
    logic [31:0] m_cyc, m_stl, m_fls;
    int          n_chk, n_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (RegWriteM && RD_M != 0 && RD_M == rs) return 2'b10;
        if (RegWriteW && RDW != 0 && RDW == rs)   return 2'b01;
        return 2'b00;
    endfunction

    task automatic zero_inputs();
        start = 0; halt_req = 0;
        RS1_D = 0; RS2_D = 0; RS1_E = 0; RS2_E = 0; RD_E = 0; RD_M = 0; RDW = 0;
        ResultSrcE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
    endtask

    task automatic drive_rand(input int halt_pct, input int rst_pct);
        RS1_D = 5'($urandom_range(0, 3)); RS2_D = 5'($urandom_range(0, 3));
        RS1_E = 5'($urandom_range(0, 3)); RS2_E = 5'($urandom_range(0, 3));
        RD_E  = 5'($urandom_range(0, 3)); RD_M  = 5'($urandom_range(0, 3));
        RDW   = 5'($urandom_range(0, 3));
        ResultSrcE = ($urandom_range(0, 2) == 0);
        RegWriteM  = $urandom_range(0, 1) != 0;
        RegWriteW  = $urandom_range(0, 1) != 0;
        PCSrcE     = ($urandom_range(0, 4) == 0);
        start      = ($urandom_range(0, 7) == 0);
        halt_req   = ($urandom_range(0, 99) < halt_pct);
        rst        = ($urandom_range(0, 99) < rst_pct);
    endtask

    // Check at the falling edge, then advance the model across the next rising edge.
    task automatic step();
        bit lw, acc, idle_vals, e_sf, e_sd, e_fd, e_fe;
        logic [31:0] e_c, e_s, e_f;
        @(negedge clk);
        lw  = ResultSrcE && RD_E != 0 && (RD_E == RS1_D || RD_E == RS2_D);
        acc = !rst && m_mode == 1 && halt_req && !PCSrcE && !lw;
        idle_vals = rst || m_mode != 1;
        e_sd = idle_vals ? 1'b1 : (lw && !PCSrcE);
        e_sf = idle_vals ? 1'b1 : ((lw && !PCSrcE) || acc);
        e_fd = idle_vals ? 1'b1 : (PCSrcE || acc);
        e_fe = idle_vals ? 1'b1 : (lw || PCSrcE || acc);
`ifdef HAZARD_PERF_CNT_EN
        e_c = m_cyc; e_s = m_stl; e_f = m_fls;
`else
        e_c = 0; e_s = 0; e_f = 0;
`endif
        chk("StallF",    32'(StallF),    32'(e_sf));
        chk("StallD",    32'(StallD),    32'(e_sd));
        chk("FlushD",    32'(FlushD),    32'(e_fd));
        chk("FlushE",    32'(FlushE),    32'(e_fe));
        chk("ForwardAE", 32'(ForwardAE), 32'(ref_fwd(RS1_E)));
        chk("ForwardBE", 32'(ForwardBE), 32'(ref_fwd(RS2_E)));
        chk("running",   32'(running),   32'(m_mode == 1));
        chk("halted",    32'(halted),    32'(m_mode == 3));
        chk("cycle_cnt", cycle_cnt, e_c);
        chk("stall_cnt", stall_cnt, e_s);
        chk("flush_cnt", flush_cnt, e_f);
        if (rst) begin
            m_mode = 0; m_cyc = 0; m_stl = 0; m_fls = 0;
        end else begin
            case (m_mode)
                0: if (start) m_mode = 1;
                1: begin
                    m_cyc++;
                    if (lw && !PCSrcE) m_stl++;
                    if (PCSrcE) m_fls++;
                    if (acc) begin m_mode = 2; m_since_acc = 0; end
                end
                2: begin
                    m_cyc++;
                    m_since_acc++;
                    if (m_since_acc == 2) m_mode = 3;
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        m_mode = 0; m_since_acc = 0; m_cyc = 0; m_stl = 0; m_fls = 0;
        zero_inputs();
        rst = 1;
        step(); step();
        rst = 0;
        repeat (5) begin drive_rand(0, 0); start = 0; step(); end
        zero_inputs();
        start = 1; step();
        start = 0; step();

        ResultSrcE = 1; RD_E = 5; RS2_D = 5; step();
        RD_E = 0; step();
        zero_inputs();

        RS1_E = 3; RD_M = 3; RDW = 3; RegWriteM = 1; RegWriteW = 1; step();
        RegWriteM = 0; step();
        RS1_E = 0; RD_M = 0; step();
        zero_inputs();

        ResultSrcE = 1; RD_E = 5; RS2_D = 5; PCSrcE = 1; step();
        zero_inputs();

        repeat (200) begin drive_rand(0, 0); step(); end
        zero_inputs();

`ifdef HAZARD_PERF_CNT_EN
        force dut.cycle_q = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_q;
        m_cyc = 32'hFFFF_FFFF;
        step(); step();
`endif

        halt_req = 1; step();
        halt_req = 0; step(); step();
        start = 1; step();
        start = 0; repeat (3) step();

        rst = 1; step();
        rst = 0; start = 1; step();
        start = 0; halt_req = 1; PCSrcE = 1; step();
        zero_inputs(); repeat (3) step();

        halt_req = 1; step();
        halt_req = 0; step();
        rst = 1; step();
        rst = 0; repeat (2) step();

        for (int ep = 0; ep < 25; ep++) begin
            zero_inputs(); rst = 1; step();
            rst = 0; start = 1; step();
            for (int c = 0; c < 60; c++) begin
                drive_rand(8, 1);
                step();
            end
        end
        zero_inputs(); rst = 0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
